pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised successor to the single-bit program-counter slice: a WIDTH-bit program counter with its own synchronous incrementer.
- Sources for a new value: bus load, front-panel switch load, call and return through a DEPTH-entry return stack.
- Places the PC on the shared wired-AND address bus.
- Sits between the control sequencer, the front panel and the address bus of the Q2 datapath.

Parameters:
- WIDTH, 12, PC and bus width in bits.
- DEPTH, 4, return-stack entries; power of two, >= 2.
- RESET_VEC, 0, PC value after reset and after a stack underflow.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- nrst  input  1  asynchronous active-low reset.
- inc  input  1  advance PC by 1.
- nwr  input  1  active-low: load PC from xin.
- xin  input  WIDTH  bus value for load/call target.
- call  input  1  push PC+1, load PC from xin.
- ret  input  1  pop top of stack into PC.
- nsw  input  1  active-low front-panel deposit: load PC from sw_val.
- sw_val  input  WIDTH  front-panel switch value.
- rd  input  1  drive PC onto abus.
- clr_flags  input  1  clear sticky ovf/unf.
- abus  inout  WIDTH  wired-AND bus; external pull-up.
- pc  output  WIDTH  current PC.
- sp  output  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
- ovf  output  1  sticky overflow.
- unf  output  1  sticky underflow.

Behaviour:
- Reset (nrst low, asynchronous): pc=RESET_VEC, sp=0, ovf=0, unf=0. Stack contents are don't-care.
- Reset mid-call or mid-ret: the operation is abandoned; no partial push/pop.
- One PC update per cycle. Priority: nsw > nwr > call > ret > inc. Lower-priority requests in the same cycle are ignored entirely, with no stack or flag side effect.
- Increment: pc <= pc+1 mod 2^WIDTH. All-ones wraps to 0 with no flag.
- Load from xin (nwr low) or sw_val (nsw low): takes effect at the next edge, 1-cycle latency.
- Call: the stack entry at write pointer <= pc+1 (mod 2^WIDTH); pc <= xin; sp increments.
- Call when sp==DEPTH: the oldest entry is overwritten (ring), sp stays DEPTH, ovf<=1.
- Ret with sp>0: pc <= top entry; sp decrements.
- Ret with sp==0: pc <= RESET_VEC, sp stays 0, unf<=1.
- Stack is a ring buffer with WIDTH-bit entries. The top pointer wraps mod DEPTH.
- clr_flags: clears ovf/unf at the next edge. A set event in the same cycle wins; the flag stays 1.
- Bus read: combinational. While rd=1, abus[i] is driven 0 where pc[i]==0 and released (Z) where pc[i]==1; all bits are Z when rd=0.
- The bus always presents the registered PC. With rd and nwr both active, the old PC is read and the new PC appears next cycle.
- xin is sampled independently of abus. The block never reads its own bus drive.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Enabled: adds input rel (1 bit) between call and ret in priority. On rel, pc <= pc + sign-extended xin (two's complement, mod 2^WIDTH); the stack is untouched.
- Disabled: no rel port, no adder beyond the incrementer; behaviour otherwise identical.

Decomposition:
- Package pc_stack_pkg holds:
  - the op-select enum {OP_NONE, OP_SW, OP_LOAD, OP_CALL, OP_RET, OP_REL, OP_INC};
  - the function computing the selected op from request inputs;
  - the sp width constant function.
- Sub-module ret_ring: DEPTH x WIDTH ring storage with push/pop, occupancy counter and overflow/underflow strobes. The top level holds the PC register, priority select, flags and bus driver.

Test Plan:
- Reset then inc x3 -> pc=3. Load xin=0xFFF via nwr, then inc -> pc=0x000, ovf=unf=0.
- pc=0x010, call xin=0x200 -> pc=0x200, sp=1. Ret -> pc=0x011, sp=0.
- DEPTH=4: five nested calls from pc=0x100,0x200,0x300,0x400,0x500 -> sp=4, ovf=1. Four rets yield 0x501,0x401,0x301,0x201; a fifth ret -> pc=RESET_VEC, unf=1.
- Same cycle nsw=0 (sw_val=0x055), nwr=0 (xin=0x0AA), call=1, inc=1 -> pc=0x055, sp unchanged.
- pc=0x5A3, rd=1 with pull-up -> abus=0x5A3 (zeros driven, ones Z). rd=0 -> abus all Z.
- PC_REL_BRANCH_EN: pc=0x010, rel=1, xin=0xFFE -> pc=0x00E. Assert nrst low mid-call -> pc=RESET_VEC, sp=0, flags 0 immediately, no clock required.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the pc_stack program counter and its return ring.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SW,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_REL,
    OP_INC
  } op_e;

  // Fixed priority: front-panel deposit > bus load > call > relative branch > return > increment.
  function automatic op_e sel_op(input logic nsw, input logic nwr, input logic call,
                                 input logic rel, input logic ret, input logic inc);
    if (!nsw)      return OP_SW;
    else if (!nwr) return OP_LOAD;
    else if (call) return OP_CALL;
    else if (rel)  return OP_REL;
    else if (ret)  return OP_RET;
    else if (inc)  return OP_INC;
    return OP_NONE;
  endfunction

  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ret_ring.sv
// DEPTH x WIDTH return-address ring: push overwrites the oldest entry when full,
// pop on empty only raises the underflow strobe.
module ret_ring import pc_stack_pkg::*; #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              push_data,
  output logic [WIDTH-1:0]              pop_data,
  output logic [sp_width(DEPTH)-1:0]    sp,
  output logic                          ovf_stb,
  output logic                          unf_stb
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = sp_width(DEPTH);
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [SPW-1:0]   cnt;
  logic             full;
  logic             empty;

  assign full     = (cnt == FULL);
  assign empty    = (cnt == '0);
  assign ovf_stb  = push && full;
  assign unf_stb  = pop && empty;
  assign pop_data = mem[wp - AW'(1)];
  assign sp       = cnt;

  // When full, wp already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp + AW'(1);
      if (!full) cnt <= cnt + SPW'(1);
    end else if (pop && !empty) begin
      wp  <= wp - AW'(1);
      cnt <= cnt - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && nrst) mem[wp] <= push_data;
  end

endmodule

// File: rtl/pc_stack.sv
// WIDTH-bit program counter with return-stack call/ret and wired-AND bus drive.
// Optional relative branch input enabled by defining PC_REL_BRANCH_EN.
module pc_stack import pc_stack_pkg::*; #(
  parameter int unsigned      WIDTH     = 12,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       inc,
  input  logic                       nwr,
  input  logic [WIDTH-1:0]           xin,
  input  logic                       call,
`ifdef PC_REL_BRANCH_EN
  input  logic                       rel,
`endif
  input  logic                       ret,
  input  logic                       nsw,
  input  logic [WIDTH-1:0]           sw_val,
  input  logic                       rd,
  input  logic                       clr_flags,
  inout  wire  [WIDTH-1:0]           abus,
  output logic [WIDTH-1:0]           pc,
  output logic [sp_width(DEPTH)-1:0] sp,
  output logic                       ovf,
  output logic                       unf
);

  op_e              op;
  logic             rel_req;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pop_data;
  logic             push;
  logic             pop;
  logic             ovf_stb;
  logic             unf_stb;

`ifdef PC_REL_BRANCH_EN
  assign rel_req = rel;
`else
  assign rel_req = 1'b0;
`endif

  assign op     = sel_op(nsw, nwr, call, rel_req, ret, inc);
  assign pc_inc = pc + WIDTH'(1);

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_SW:   pc_next = sw_val;
      OP_LOAD: pc_next = xin;
      OP_CALL: begin
        pc_next = xin;
        push    = 1'b1;
      end
`ifdef PC_REL_BRANCH_EN
      // xin and pc share a width, so a modular add equals the sign-extended add.
      OP_REL:  pc_next = pc + xin;
`endif
      OP_RET: begin
        pop     = 1'b1;
        pc_next = (sp != '0) ? pop_data : RESET_VEC;
      end
      OP_INC:  pc_next = pc_inc;
      default: pc_next = pc;
    endcase
  end

  ret_ring #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .sp        (sp),
    .ovf_stb   (ovf_stb),
    .unf_stb   (unf_stb)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc  <= RESET_VEC;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      pc  <= pc_next;
      ovf <= ovf_stb | (ovf & ~clr_flags);
      unf <= unf_stb | (unf & ~clr_flags);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bus
    assign abus[i] = (rd && !pc[i]) ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: vector table through a scoreboard queue, plus bus and reset sequences.
module tb_pc_stack;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         inc = 1'b0, nwr = 1'b1, call = 1'b0, ret = 1'b0, nsw = 1'b1;
  logic         rd = 1'b0, clr_flags = 1'b0;
  logic [W-1:0] xin = '0, sw_val = '0;
  wire  [W-1:0] abus_w;
  logic [W-1:0] pc;
  logic [2:0]   sp;
  logic         ovf, unf;
`ifdef PC_REL_BRANCH_EN
  logic         rel = 1'b0;
`endif

  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (abus_w[i]);
  end

  always #5 clk = ~clk;

  pc_stack #(
    .WIDTH     (W),
    .DEPTH     (4),
    .RESET_VEC (12'h000)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .inc       (inc),
    .nwr       (nwr),
    .xin       (xin),
    .call      (call),
`ifdef PC_REL_BRANCH_EN
    .rel       (rel),
`endif
    .ret       (ret),
    .nsw       (nsw),
    .sw_val    (sw_val),
    .rd        (rd),
    .clr_flags (clr_flags),
    .abus      (abus_w),
    .pc        (pc),
    .sp        (sp),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct {
    logic nsw, nwr, call, ret, rel, inc, clr;
    logic [W-1:0] xin, sw;
    logic [W-1:0] pc;
    logic [2:0]   sp;
    logic         ovf, unf;
  } vec_t;

  typedef struct {
    logic [W-1:0] pc;
    logic [2:0]   sp;
    logic         ovf, unf;
    int           idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  function automatic vec_t v(input logic nsw_i, input logic nwr_i, input logic call_i,
                             input logic ret_i, input logic rel_i, input logic inc_i,
                             input logic clr_i, input logic [W-1:0] xin_i,
                             input logic [W-1:0] sw_i, input logic [W-1:0] pc_i,
                             input logic [2:0] sp_i, input logic ovf_i, input logic unf_i);
    vec_t r;
    r.nsw = nsw_i; r.nwr = nwr_i; r.call = call_i; r.ret = ret_i; r.rel = rel_i;
    r.inc = inc_i; r.clr = clr_i; r.xin = xin_i; r.sw = sw_i;
    r.pc = pc_i; r.sp = sp_i; r.ovf = ovf_i; r.unf = unf_i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".pc"},  32'(pc),  32'(e.pc));
    chk({tag, ".sp"},  32'(sp),  32'(e.sp));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    chk({tag, ".unf"}, 32'(unf), 32'(e.unf));
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk);
    nsw = t.nsw; nwr = t.nwr; call = t.call; ret = t.ret; inc = t.inc;
    clr_flags = t.clr; xin = t.xin; sw_val = t.sw;
`ifdef PC_REL_BRANCH_EN
    rel = t.rel;
`endif
    sb.push_back('{pc: t.pc, sp: t.sp, ovf: t.ovf, unf: t.unf, idx: vcount});
    vcount++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_state($sformatf("v%0d", e.idx), e);
  endtask

  initial begin
    exp_t rst_e;
    // nsw nwr call ret rel inc clr  xin      sw       -> pc      sp ovf unf
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 12'h001, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 12'h002, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 12'h003, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12'hFFF, 12'h000, 12'hFFF, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12'h010, 12'h000, 12'h010, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h200, 12'h000, 12'h200, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h011, 0, 0, 0));
`ifdef PC_REL_BRANCH_EN
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12'h010, 12'h000, 12'h010, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 12'hFFE, 12'h000, 12'h00E, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 1, 0, 12'h002, 12'h000, 12'h010, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 0, 12'h020, 12'h000, 12'h020, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h011, 0, 0, 0));
`endif
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12'h100, 12'h000, 12'h100, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h200, 12'h000, 12'h200, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h300, 12'h000, 12'h300, 2, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h400, 12'h000, 12'h400, 3, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h500, 12'h000, 12'h500, 4, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h600, 12'h000, 12'h600, 4, 1, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h501, 3, 1, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h401, 2, 1, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h301, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h201, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 1, 1));
    // clear with a simultaneous underflow: unf set wins, ovf clears
    tbl.push_back(v(1, 1, 0, 1, 0, 0, 1, 12'h000, 12'h000, 12'h000, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 12'h123, 12'h000, 12'h123, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 0, 12'h0AA, 12'h055, 12'h055, 1, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 0, 1, 0, 12'h0AA, 12'h000, 12'h0AA, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 0, 1, 0, 12'h300, 12'h000, 12'h300, 2, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 0, 1, 0, 12'h000, 12'h000, 12'h0AB, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12'h5A3, 12'h000, 12'h5A3, 1, 0, 0));

    // reset state, bus released
    #3;
    rst_e = '{pc: 12'h000, sp: 3'd0, ovf: 1'b0, unf: 1'b0, idx: 0};
    chk_state("reset", rst_e);
    chk("reset.abus", 32'(abus_w), 32'hFFF);
    @(negedge clk);
    nrst = 1'b1;

    foreach (tbl[k]) apply(tbl[k]);

    // bus drive: pc=0x5A3
    @(negedge clk);
    nsw = 1'b1; nwr = 1'b1; call = 1'b0; ret = 1'b0; inc = 1'b0; clr_flags = 1'b0;
    rd = 1'b1;
    #1 chk("bus.rd1", 32'(abus_w), 32'h5A3);
    rd = 1'b0;
    #1 chk("bus.rd0", 32'(abus_w), 32'hFFF);
    rd = 1'b1; nwr = 1'b0; xin = 12'h0F0;
    #1 chk("bus.old", 32'(abus_w), 32'h5A3);
    @(posedge clk);
    #1;
    chk("bus.newpc", 32'(pc), 32'h0F0);
    chk("bus.new", 32'(abus_w), 32'h0F0);
    @(negedge clk);
    rd = 1'b0; nwr = 1'b1;

    apply(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h001, 0, 0, 0));
    apply(v(1, 1, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 1));
    apply(v(1, 1, 1, 0, 0, 0, 0, 12'h777, 12'h000, 12'h777, 1, 0, 1));

    // asynchronous reset in the middle of a call, before its edge
    @(negedge clk);
    call = 1'b1; xin = 12'h888;
    #2 nrst = 1'b0;
    #1 chk_state("arst", rst_e);
    @(posedge clk);
    #1 chk_state("arst_hold", rst_e);
    @(negedge clk);
    call = 1'b0;
    nrst = 1'b1;
    apply(v(1, 1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 12'h001, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
